minmax_track: RTL and testbench

- Streaming min/max tracker that consumes unsigned W-bit samples over a valid/ready handshake.
- Per window, it reports the minimum and maximum value, the sample index of each, and the sample count.
- Ordering decisions come from two instances of the team's hierarchical comparator (lt/eq/gt), one comparing against the running minimum and one against the running maximum.
- Sits downstream of sample sources (ADC capture, counters) and upstream of threshold/statistics logic.

---
 rtl/minmax_track_pkg.sv | 14 +
 rtl/minmax_track_cmp.sv | 42 ++++
 rtl/minmax_track.sv | 161 ++++++++++++++++
 tb/tb_minmax_track.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/minmax_track_pkg.sv
// Shared types and helpers for minmax_track and the comparator family.
package minmax_track_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int unsigned cmp_width(input int unsigned order);
    return 32'd1 << order;
  endfunction

endpackage

// File: rtl/minmax_track_cmp.sv
// Hierarchical unsigned comparator: 2**LIMIT-bit leaf chunks merged MSB-first
// through a binary tree into lt/eq/gt for a W = 2**ORDER bit compare.
module cmp
  import minmax_track_pkg::*;
#(
  parameter int unsigned ORDER = 3,
  parameter int unsigned LIMIT = 0
) (
  input  logic [cmp_width(ORDER)-1:0] i_a,
  input  logic [cmp_width(ORDER)-1:0] i_b,
  output logic                        o_lt,
  output logic                        o_eq,
  output logic                        o_gt
);

  localparam int unsigned W     = cmp_width(ORDER);
  localparam int unsigned CWID  = cmp_width(LIMIT);
  localparam int unsigned NL    = W / CWID;
  localparam int unsigned NODES = 2 * NL - 1;

  // Heap layout: node p has hi child 2p+1 and lo child 2p+2; leaves start at NL-1.
  logic [NODES-1:0] w_lt;
  logic [NODES-1:0] w_eq;

  always_comb begin
    w_lt = '0;
    w_eq = '0;
    for (int unsigned k = 0; k < NL; k++) begin
      w_lt[NL-1+k] = i_a[(NL-1-k)*CWID +: CWID] <  i_b[(NL-1-k)*CWID +: CWID];
      w_eq[NL-1+k] = i_a[(NL-1-k)*CWID +: CWID] == i_b[(NL-1-k)*CWID +: CWID];
    end
    for (int unsigned j = NL - 1; j > 0; j--) begin
      w_lt[j-1] = w_lt[2*j-1] | (w_eq[2*j-1] & w_lt[2*j]);
      w_eq[j-1] = w_eq[2*j-1] & w_eq[2*j];
    end
  end

  assign o_lt = w_lt[0];
  assign o_eq = w_eq[0];
  assign o_gt = ~(w_lt[0] | w_eq[0]);

endmodule

// File: rtl/minmax_track.sv
// Streaming per-window min/max tracker with first-occurrence indices and count,
// valid/ready on both sides; results are registered and held until handoff.
module minmax_track
  import minmax_track_pkg::*;
#(
  parameter int unsigned ORDER     = 3,
  parameter int unsigned LEN_ORDER = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [cmp_width(ORDER)-1:0] s_data,
  input  logic                        s_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [cmp_width(ORDER)-1:0] m_min,
  output logic [cmp_width(ORDER)-1:0] m_max,
  output logic [LEN_ORDER-1:0]        m_min_idx,
  output logic [LEN_ORDER-1:0]        m_max_idx,
  output logic [LEN_ORDER:0]          m_count
);

  localparam int unsigned W  = cmp_width(ORDER);
  localparam int unsigned N  = 32'd1 << LEN_ORDER;
  localparam int unsigned IW = LEN_ORDER;
  localparam int unsigned CW = LEN_ORDER + 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_s_ready;
  logic            r_m_valid;
  logic [W-1:0]    r_min;
  logic [W-1:0]    r_max;
  logic [IW-1:0]   r_min_idx;
  logic [IW-1:0]   r_max_idx;
  logic [CW-1:0]   r_count;

  logic            w_accept;
  logic            w_handoff;
  logic            w_close;
  logic [CW-1:0]   w_cnt_nxt;
  logic [W-1:0]    w_min_nxt;
  logic [W-1:0]    w_max_nxt;
  logic [IW-1:0]   w_min_idx_nxt;
  logic [IW-1:0]   w_max_idx_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic            w_ready_nxt;
  logic            w_valid_nxt;

  logic            w_min_lt;
  logic            w_min_eq;
  logic            w_min_gt;
  logic            w_max_lt;
  logic            w_max_eq;
  logic            w_max_gt;

  cmp #(.ORDER(ORDER)) u_cmp_min (
    .i_a  (s_data),
    .i_b  (r_min),
    .o_lt (w_min_lt),
    .o_eq (w_min_eq),
    .o_gt (w_min_gt)
  );

  cmp #(.ORDER(ORDER)) u_cmp_max (
    .i_a  (s_data),
    .i_b  (r_max),
    .o_lt (w_max_lt),
    .o_eq (w_max_eq),
    .o_gt (w_max_gt)
  );

  // Exactly one of lt/eq/gt must hold on every compare.
  a_min_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot({w_min_lt, w_min_eq, w_min_gt}));
  a_max_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot({w_max_lt, w_max_eq, w_max_gt}));

  assign w_accept  = s_valid & r_s_ready;
  assign w_handoff = r_m_valid & m_ready;
  assign w_cnt_nxt = (r_state == ST_IDLE) ? CW'(1) : r_count + CW'(1);
  assign w_close   = s_last | (w_cnt_nxt == CW'(N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)             w_state_nxt = w_close ? ST_DONE : ST_ACC;
      ST_ACC:  if (w_accept && w_close)  w_state_nxt = ST_DONE;
      ST_DONE: if (w_handoff)            w_state_nxt = ST_IDLE;
      default:                           w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_min_nxt     = r_min;
    w_max_nxt     = r_max;
    w_min_idx_nxt = r_min_idx;
    w_max_idx_nxt = r_max_idx;
    w_count_nxt   = r_count;
    if (w_accept) begin
      if (r_state == ST_IDLE) begin
        w_min_nxt     = s_data;
        w_max_nxt     = s_data;
        w_min_idx_nxt = '0;
        w_max_idx_nxt = '0;
        w_count_nxt   = w_cnt_nxt;
      end else if (r_state == ST_ACC) begin
        // Strict compares only, so ties keep the earliest index.
        if (w_min_lt) begin
          w_min_nxt     = s_data;
          w_min_idx_nxt = r_count[IW-1:0];
        end
        if (w_max_gt) begin
          w_max_nxt     = s_data;
          w_max_idx_nxt = r_count[IW-1:0];
        end
        w_count_nxt = w_cnt_nxt;
      end
    end
    w_ready_nxt = (w_state_nxt != ST_DONE);
    w_valid_nxt = (w_state_nxt == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_min     <= '0;
      r_max     <= '0;
      r_min_idx <= '0;
      r_max_idx <= '0;
      r_count   <= '0;
    end else begin
      r_s_ready <= w_ready_nxt;
      r_m_valid <= w_valid_nxt;
      r_min     <= w_min_nxt;
      r_max     <= w_max_nxt;
      r_min_idx <= w_min_idx_nxt;
      r_max_idx <= w_max_idx_nxt;
      r_count   <= w_count_nxt;
    end
  end

  assign s_ready   = r_s_ready;
  assign m_valid   = r_m_valid;
  assign m_min     = r_min;
  assign m_max     = r_max;
  assign m_min_idx = r_min_idx;
  assign m_max_idx = r_max_idx;
  assign m_count   = r_count;

endmodule

// File: tb/tb_minmax_track.sv
// Directed bench for minmax_track (ORDER=3, LEN_ORDER=2, N=4): vector table plus
// hand sequences for reset, backpressure and mid-window reset.
module tb_minmax_track;

  localparam int unsigned ORDER     = 3;
  localparam int unsigned LEN_ORDER = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_min;
  logic [7:0] m_max;
  logic [1:0] m_min_idx;
  logic [1:0] m_max_idx;
  logic [2:0] m_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  minmax_track #(.ORDER(ORDER), .LEN_ORDER(LEN_ORDER)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_min     (m_min),
    .m_max     (m_max),
    .m_min_idx (m_min_idx),
    .m_max_idx (m_max_idx),
    .m_count   (m_count)
  );

  typedef struct {
    int         n;
    logic [7:0] v;
    logic [7:0] l;
    logic [7:0] d [8];
    logic [7:0] emin;
    logic [1:0] eminidx;
    logic [7:0] emax;
    logic [1:0] emaxidx;
    logic [2:0] ecnt;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] emin, input logic [1:0] eminidx,
                              input logic [7:0] emax, input logic [1:0] emaxidx,
                              input logic [2:0] ecnt);
    chk({tag, " min"},     32'(m_min),     32'(emin));
    chk({tag, " min_idx"}, 32'(m_min_idx), 32'(eminidx));
    chk({tag, " max"},     32'(m_max),     32'(emax));
    chk({tag, " max_idx"}, 32'(m_max_idx), 32'(emaxidx));
    chk({tag, " count"},   32'(m_count),   32'(ecnt));
  endtask

  task automatic send(input logic v, input logic [7:0] d, input logic l);
    s_valid = v;
    s_data  = d;
    s_last  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input int idx, input string tag);
    for (int c = 0; c < vecs[idx].n; c++) begin
      send(vecs[idx].v[c], vecs[idx].d[c], vecs[idx].l[c]);
      if (c < vecs[idx].n - 1) chk({tag, " early_valid"}, 32'(m_valid), 32'd0);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk({tag, " m_valid"}, 32'(m_valid), 32'd1);
    chk({tag, " s_ready"}, 32'(s_ready), 32'd0);
    check_result(tag, vecs[idx].emin, vecs[idx].eminidx, vecs[idx].emax,
                 vecs[idx].emaxidx, vecs[idx].ecnt);
  endtask

  initial begin
    vecs[0] = '{4, 8'b00001111, 8'b00000000,
                '{8'd5, 8'd200, 8'd3, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0},
                8'd3, 2'd2, 8'd200, 2'd1, 3'd4};
    vecs[1] = '{1, 8'b00000001, 8'b00000001,
                '{8'd17, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                8'd17, 2'd0, 8'd17, 2'd0, 3'd1};
    vecs[2] = '{7, 8'b01011001, 8'b00000000,
                '{8'd9, 8'd1, 8'd250, 8'd4, 8'd12, 8'd250, 8'd4, 8'd0},
                8'd4, 2'd1, 8'd12, 2'd2, 3'd4};
    vecs[3] = '{4, 8'b00001111, 8'b00000000,
                '{8'd7, 8'd7, 8'd7, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0},
                8'd7, 2'd0, 8'd7, 2'd0, 3'd4};
    vecs[4] = '{3, 8'b00000111, 8'b00000100,
                '{8'd10, 8'd20, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                8'd5, 2'd2, 8'd20, 2'd1, 3'd3};
    vecs[5] = '{4, 8'b00001111, 8'b00001000,
                '{8'd8, 8'd6, 8'd9, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0},
                8'd1, 2'd3, 8'd9, 2'd2, 3'd4};
    vecs[6] = '{4, 8'b00001111, 8'b00000000,
                '{8'd200, 8'd150, 8'd100, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0},
                8'd50, 2'd3, 8'd200, 2'd0, 3'd4};
    vecs[7] = '{4, 8'b00001111, 8'b00000000,
                '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0},
                8'd1, 2'd0, 8'd4, 2'd3, 3'd4};

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;

    // Reset values, then s_ready rises only on the first edge after release.
    repeat (3) @(posedge clk);
    #1;
    chk("rst s_ready", 32'(s_ready), 32'd0);
    chk("rst m_valid", 32'(m_valid), 32'd0);
    check_result("rst", 8'd0, 2'd0, 8'd0, 2'd0, 3'd0);
    #2 rst_n = 1'b1;
    #1;
    chk("rel s_ready_pre_edge", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rel s_ready_post_edge", 32'(s_ready), 32'd1);

    for (int i = 0; i < 7; i++) begin
      run_window(i, $sformatf("vec%0d", i));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d handoff m_valid", i), 32'(m_valid), 32'd0);
      chk($sformatf("vec%0d handoff s_ready", i), 32'(s_ready), 32'd1);
    end

    // Backpressure with edge values; a sample offered during DONE must be ignored.
    m_ready = 1'b0;
    send(1'b1, 8'd0,   1'b0);
    send(1'b1, 8'd255, 1'b0);
    send(1'b1, 8'd255, 1'b0);
    send(1'b1, 8'd0,   1'b0);
    s_valid = 1'b1;
    s_data  = 8'd99;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d m_valid", k), 32'(m_valid), 32'd1);
      chk($sformatf("bp%0d s_ready", k), 32'(s_ready), 32'd0);
      check_result($sformatf("bp%0d", k), 8'd0, 2'd0, 8'd255, 2'd1, 3'd4);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp handoff m_valid", 32'(m_valid), 32'd0);
    chk("bp handoff s_ready", 32'(s_ready), 32'd1);
    check_result("bp held", 8'd0, 2'd0, 8'd255, 2'd1, 3'd4);

    // Asynchronous reset between edges discards a partial window.
    send(1'b1, 8'd50, 1'b0);
    send(1'b1, 8'd60, 1'b0);
    s_valid = 1'b0;
    chk("mid pre_rst count", 32'(m_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst m_valid", 32'(m_valid), 32'd0);
    chk("mid rst s_ready", 32'(s_ready), 32'd0);
    check_result("mid rst", 8'd0, 2'd0, 8'd0, 2'd0, 3'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid rel s_ready", 32'(s_ready), 32'd1);
    run_window(7, "post_rst");
    @(posedge clk);
    #1;
    chk("post_rst handoff m_valid", 32'(m_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
